// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared external ALU: IDLE -> EXEC -> RESP.
// Build macro ALU_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_Ain,
   input  logic [DATA_W-1:0] req0_Bin,
   input  logic [1:0]        req0_ALUop,
   input  logic [DATA_W-1:0] req1_Ain,
   input  logic [DATA_W-1:0] req1_Bin,
   input  logic [1:0]        req1_ALUop,
   output logic [DATA_W-1:0] alu_Ain,
   output logic [DATA_W-1:0] alu_Bin,
   output logic [1:0]        alu_ALUop,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_Z,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_out,
   output logic              rsp_Z,
   output logic              rsp_id,
   output logic [1:0]        fsm_state
);

   // Handshakes: a request transfers on a rising edge where req_valid[i] and req_ready[i]
   // are both high; a response transfers on an edge where rsp_valid and rsp_ready are both high.
   // req_ready is combinational from req_valid and may only rise in IDLE; rsp_valid is registered.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic [1:0]          op_code;
   logic                op_id;
   logic                any_req;
   logic                grant_id;
`ifdef ALU_ARB_RR_EN
   logic                last_grant;
`endif

   always_comb begin
      any_req  = |req_valid;
      grant_id = ~req_valid[0];
`ifdef ALU_ARB_RR_EN
      if (&req_valid) begin
         grant_id = ~last_grant;
      end
`endif
   end

   assign req_ready = (state == IDLE && any_req) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

   // The shared ALU only ever sees the captured operands, so requesters are free after accept.
   assign alu_Ain   = op_a;
   assign alu_Bin   = op_b;
   assign alu_ALUop = op_code;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_code   <= 2'b00;
         op_id     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_out   <= '0;
         rsp_Z     <= 1'b0;
         rsp_id    <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  op_a    <= grant_id ? req1_Ain   : req0_Ain;
                  op_b    <= grant_id ? req1_Bin   : req0_Bin;
                  op_code <= grant_id ? req1_ALUop : req0_ALUop;
                  op_id   <= grant_id;
`ifdef ALU_ARB_RR_EN
                  last_grant <= grant_id;
`endif
                  state   <= EXEC;
               end
            end
            EXEC: begin
               rsp_out   <= alu_out;
               rsp_Z     <= alu_Z;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ready));
   a_ready_only_idle: assert property (@(posedge clk) disable iff (!reset_n)
      (req_ready != 2'b00) |-> (state == IDLE));
   a_rsp_hold: assert property (@(posedge clk) disable iff (!reset_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_out) && $stable(rsp_Z) && $stable(rsp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: external ALU model, per-cycle transaction model with an expected
// response queue, and directed vectors with literal expectations.
module tb_alu_arbiter;
   localparam int DATA_W = 16;
   localparam int W      = DATA_W + 2;
`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [1:0]        req_valid = 2'b00;
   logic [1:0]        req_ready;
   logic [DATA_W-1:0] req0_Ain = '0, req0_Bin = '0, req1_Ain = '0, req1_Bin = '0;
   logic [1:0]        req0_ALUop = 2'b00, req1_ALUop = 2'b00;
   logic [DATA_W-1:0] alu_Ain, alu_Bin, alu_out, rsp_out;
   logic [1:0]        alu_ALUop, fsm_state;
   logic              alu_Z, rsp_valid, rsp_Z, rsp_id;
   logic              rsp_ready = 1'b1;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_Ain(req0_Ain), .req0_Bin(req0_Bin), .req0_ALUop(req0_ALUop),
      .req1_Ain(req1_Ain), .req1_Bin(req1_Bin), .req1_ALUop(req1_ALUop),
      .alu_Ain(alu_Ain), .alu_Bin(alu_Bin), .alu_ALUop(alu_ALUop),
      .alu_out(alu_out), .alu_Z(alu_Z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_Z(rsp_Z), .rsp_id(rsp_id),
      .fsm_state(fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   // ---------------- shared ALU and reference functions ----------------
   function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return ~b;
      endcase
   endfunction

   function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
      if (v == 2'b11) return (RR && !last) ? 2'b10 : 2'b01;
      return v;
   endfunction

   assign alu_out = alu_ref(alu_Ain, alu_Bin, alu_ALUop);
   assign alu_Z   = (alu_out == '0);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / per-cycle compare ----------------
   logic [W-1:0]      exp_q[$];
   logic              m_busy = 1'b0;
   int                m_age = 0;
   logic              m_last = 1'b1;
   logic [DATA_W-1:0] m_a = '0, m_b = '0;
   logic [1:0]        m_op = 2'b00;

   always @(negedge clk) begin : compare
      logic [1:0]        g;
      logic              ev;
      logic [W-1:0]      e;
      logic [DATA_W-1:0] r;
      if (!reset_n) begin
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_req_ready", req_ready, 0);
         check("rst_alu_Ain", alu_Ain, 0);
         check("rst_alu_ALUop", alu_ALUop, 0);
         exp_q.delete();
         m_busy = 1'b0;
         m_age  = 0;
         m_last = 1'b1;
      end else begin
         g  = 2'b00;
         ev = 1'b0;
         if (m_busy) begin
            m_age++;
            ev = (m_age >= 2);
            if (m_age == 1) begin
               check("exec_alu_Ain", alu_Ain, m_a);
               check("exec_alu_Bin", alu_Bin, m_b);
               check("exec_alu_ALUop", alu_ALUop, m_op);
            end
         end else begin
            g = model_grant(req_valid, m_last);
            if (g != 2'b00) begin
               m_busy = 1'b1;
               m_age  = 0;
               m_last = g[1];
               m_a    = g[1] ? req1_Ain : req0_Ain;
               m_b    = g[1] ? req1_Bin : req0_Bin;
               m_op   = g[1] ? req1_ALUop : req0_ALUop;
               r      = alu_ref(m_a, m_b, m_op);
               exp_q.push_back({g[1], (r == '0), r});
            end
         end
         check("req_ready", req_ready, g);
         check("rsp_valid", rsp_valid, ev);
         if (ev) begin
            if (exp_q.size() == 0) begin
               check("rsp_queue_nonempty", 0, 1);
            end else begin
               e = exp_q[0];
               check("rsp_out", rsp_out, e[DATA_W-1:0]);
               check("rsp_Z", rsp_Z, e[DATA_W]);
               check("rsp_id", rsp_id, e[DATA_W+1]);
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      step();
   endtask

   task automatic set_req(input logic id, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [1:0] op);
      if (id) begin
         req1_Ain = a; req1_Bin = b; req1_ALUop = op;
      end else begin
         req0_Ain = a; req0_Bin = b; req0_ALUop = op;
      end
   endtask

   // Issue one request, check immediate grant, 2-cycle latency and the literal result.
   task automatic single_op(input logic id, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [1:0] op, input logic [DATA_W-1:0] eo, input logic ez,
                            input string nm);
      int n;
      set_req(id, a, b, op);
      rsp_ready = 1'b1;
      req_valid = id ? 2'b10 : 2'b01;
      n = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && n < 8) begin
         n++;
         @(negedge clk);
      end
      check({nm, "_grant_wait"}, n, 0);
      check({nm, "_grant"}, req_ready, id ? 2'b10 : 2'b01);
      step();
      req_valid = 2'b00;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 8) begin
         n++;
         @(negedge clk);
      end
      check({nm, "_latency"}, n, 1);
      check({nm, "_out"}, rsp_out, eo);
      check({nm, "_Z"}, rsp_Z, ez);
      check({nm, "_id"}, rsp_id, id);
      step();
   endtask

   task automatic hold_test();
      set_req(0, 16'h1234, 16'd4, 2'b11);
      set_req(1, 16'd1, 16'd2, 2'b00);
      rsp_ready = 1'b0;
      req_valid = 2'b01;
      @(negedge clk);
      check("hold_grant", req_ready, 2'b01);
      step();
      req_valid = 2'b10;
      @(negedge clk);
      check("hold_exec_ready", req_ready, 2'b00);
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_out", rsp_out, 16'hFFFB);
         check("hold_ready", req_ready, 2'b00);
         step();
      end
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      check("hold_retire_valid", rsp_valid, 1);
      check("hold_retire_out", rsp_out, 16'hFFFB);
      step();
      @(negedge clk);
      check("hold_after_valid", rsp_valid, 0);
      step();
   endtask

   task automatic reset_exec_test();
      int n;
      set_req(0, 16'd2, 16'd3, 2'b00);
      req_valid = 2'b01;
      @(negedge clk);
      check("rx_grant", req_ready, 2'b01);
      step();
      req_valid = 2'b00;
      reset_n = 1'b0;
      #1;
      check("rx_rsp_valid", rsp_valid, 0);
      check("rx_alu_Ain", alu_Ain, 0);
      check("rx_alu_Bin", alu_Bin, 0);
      check("rx_alu_ALUop", alu_ALUop, 0);
      check("rx_state", fsm_state, 0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      step();
      set_req(0, 16'd10, 16'd1, 2'b00);
      set_req(1, 16'd20, 16'd2, 2'b00);
      req_valid = 2'b11;
      @(negedge clk);
      check("rx_post_grant", req_ready, 2'b01);
      step();
      req_valid = 2'b00;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 8) begin
         n++;
         @(negedge clk);
      end
      check("rx_post_out", rsp_out, 16'd11);
      check("rx_post_id", rsp_id, 0);
      step();
   endtask

   task automatic arb_seq_test();
      int got;
      int n;
      logic [3:0] seq;
      got = 0;
      n = 0;
      seq = 4'b0000;
      set_req(0, 16'd1, 16'd1, 2'b00);
      set_req(1, 16'd2, 16'd2, 2'b00);
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      while (got < 4 && n < 40) begin
         @(negedge clk);
         if (rsp_valid) begin
            seq[got] = rsp_id;
            got++;
         end
         step();
         n++;
      end
      req_valid = 2'b00;
      check("arb_count", got, 4);
      check("arb_seq", seq, RR ? 4'b1010 : 4'b0000);
      repeat (3) step();
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      do_reset();
      @(negedge clk);
      check("reset_state", fsm_state, 0);
      check("reset_rsp_id", rsp_id, 0);
      step();
      single_op(0, 16'd3, 16'd11, 2'b00, 16'd14, 1'b0, "add");
      single_op(1, 16'd5, 16'd5, 2'b01, 16'd0, 1'b1, "sub_zero");
      single_op(1, 16'd7, 16'd9, 2'b10, 16'd1, 1'b0, "and");
      single_op(0, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, "add_wrap");
      single_op(1, 16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, "sub_borrow");
      single_op(0, 16'hAAAA, 16'h0000, 2'b11, 16'hFFFF, 1'b0, "not_zero");
      repeat (3) step();
      hold_test();
      reset_exec_test();
      do_reset();
      arb_seq_test();
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
